// File: rtl/c_addsub_pkg.sv
// ----------------------------------------------------------------------------
// c_addsub_pkg
// Shared definitions for the two-requester complex add/sub controller:
// datapath widths, requester-ID type, FSM state encoding, timeout counter
// width and the registered operand bundle handed to the shared unit.
// ----------------------------------------------------------------------------
package c_addsub_pkg;

    // Complex word is {real[63:32], imag[31:0]}.
    localparam int unsigned CPLX_W   = 64;
    localparam int unsigned PART_W   = 32;

    // Two requesters need a single ID bit.
    localparam int unsigned REQ_ID_W = 1;

    // Timeout counter holds values up to 255, the top of the legal range.
    localparam int unsigned CNT_W    = 8;

    typedef logic [REQ_ID_W-1:0] req_id_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_ARM   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // One requester's operation: both operands plus the add/sub select.
    typedef struct packed {
        logic [CPLX_W-1:0] a;
        logic [CPLX_W-1:0] b;
        logic              op;
    } cplx_req_t;

    // Pick the operation belonging to requester id.
    function automatic cplx_req_t select_req(input req_id_t   id,
                                             input cplx_req_t r0,
                                             input cplx_req_t r1);
        return (id == req_id_t'(1)) ? r1 : r0;
    endfunction

endpackage

// File: rtl/c_addsub_shared_ctrl_rr_arbiter2.sv
// ----------------------------------------------------------------------------
// rr_arbiter2
// Purely combinational two-way round-robin arbiter.
//   req0_i, req1_i : request levels
//   last_i         : requester served most recently
//   grant_o        : at least one request present
//   owner_o        : winning requester (valid when grant_o = 1)
// A single request always wins; on a tie the requester that was not served
// last wins, so neither side can be starved by the other.
// ----------------------------------------------------------------------------
module rr_arbiter2
    import c_addsub_pkg::*;
(
    input  logic    req0_i,
    input  logic    req1_i,
    input  req_id_t last_i,
    output logic    grant_o,
    output req_id_t owner_o
);

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        grant_o = req0_i | req1_i;
        owner_o = req_id_t'(0);
        if (req0_i && req1_i) begin
            owner_o = ~last_i;
        end else if (req1_i) begin
            owner_o = req_id_t'(1);
        end
    end

endmodule

// File: rtl/c_addsub_shared_ctrl.sv
// ----------------------------------------------------------------------------
// c_addsub_shared_ctrl
// Schedules two requesters onto one shared complex add/sub unit. A request is
// granted round-robin, its operands are registered, the unit is started, its
// finish is awaited with a timeout, and the result is returned to the winner
// with a one-cycle done pulse.
//
// Ports
//   clk, rst             : clock, asynchronous active-high reset
//   req0/req1            : request levels
//   A0/B0/op0, A1/B1/op1 : operands {real[63:32], imag[31:0]} and op bit
//   done0/done1          : one-cycle completion pulse to the owner
//   err0/err1            : 1 = operation aborted by timeout (valid with done)
//   result0/result1      : result, held until the next done to that requester
//   u_start/u_ce/u_op    : start pulse, clock enable and op to the shared unit
//   u_A/u_B              : operands to the shared unit
//   u_result/u_finish    : result and completion from the shared unit
//   busy                 : controller is not in IDLE
//
// Parameter
//   TIMEOUT_CYC          : WAIT cycles allowed before aborting (2..255)
// ----------------------------------------------------------------------------
module c_addsub_shared_ctrl
    import c_addsub_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [CPLX_W-1:0] A0,
    input  logic [CPLX_W-1:0] B0,
    input  logic [CPLX_W-1:0] A1,
    input  logic [CPLX_W-1:0] B1,
    input  logic              op0,
    input  logic              op1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [CPLX_W-1:0] result0,
    output logic [CPLX_W-1:0] result1,
    output logic              u_start,
    output logic              u_ce,
    output logic              u_op,
    output logic [CPLX_W-1:0] u_A,
    output logic [CPLX_W-1:0] u_B,
    input  logic [CPLX_W-1:0] u_result,
    input  logic              u_finish,
    output logic              busy
);

    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYC);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t            state_q;
    req_id_t           last_q;
    req_id_t           owner_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    cplx_req_t         u_req_q;
    logic              u_start_q;
    logic              u_ce_q;
    logic              busy_q;
    logic              done0_q;
    logic              done1_q;
    logic              err0_q;
    logic              err1_q;
    logic [CPLX_W-1:0] result0_q;
    logic [CPLX_W-1:0] result1_q;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic      grant;
    req_id_t   grant_owner;
    cplx_req_t req0_ops;
    cplx_req_t req1_ops;

    assign req0_ops = {A0, B0, op0};
    assign req1_ops = {A1, B1, op1};

    rr_arbiter2 u_arb (
        .req0_i  (req0),
        .req1_i  (req1),
        .last_i  (last_q),
        .grant_o (grant),
        .owner_o (grant_owner)
    );

    // ------------------------------------------------------------------------
    // WAIT-state resolution. A finish seen in the same cycle the counter
    // reaches the limit wins over the timeout.
    // ------------------------------------------------------------------------
    logic              wait_end;
    logic              wait_err;
    logic [CPLX_W-1:0] wait_res;

    always_comb begin
        wait_end = 1'b0;
        wait_err = 1'b0;
        wait_res = '0;
        if (u_finish) begin
            wait_end = 1'b1;
            wait_res = u_result;
        end else if (cnt_q == TIMEOUT_LIM) begin
            wait_end = 1'b1;
            wait_err = 1'b1;
        end
    end

    assign cnt_d = cnt_q + 1'b1;

    // ------------------------------------------------------------------------
    // Controller FSM. All outputs are registered and change together with the
    // state they belong to, so u_start/u_ce/done line up with ISSUE/WAIT/RESP.
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            last_q    <= req_id_t'(1);
            owner_q   <= req_id_t'(0);
            cnt_q     <= '0;
            // NOTE: the operand and result registers are reset as well,
            // because every output must read zero while reset is asserted.
            u_req_q   <= '0;
            u_start_q <= 1'b0;
            u_ce_q    <= 1'b0;
            busy_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            result0_q <= '0;
            result1_q <= '0;
        end else begin
            // Pulses default low and are raised only by the transition that
            // enters their state.
            u_start_q <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        owner_q   <= grant_owner;
                        u_req_q   <= select_req(grant_owner, req0_ops, req1_ops);
                        u_start_q <= 1'b1;
                        u_ce_q    <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_ISSUE;
                    end
                end

                // u_finish may still be high from the previous operation, so
                // it is not looked at until WAIT.
                ST_ISSUE: begin
                    state_q <= ST_ARM;
                end

                ST_ARM: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (wait_end) begin
                        if (owner_q == req_id_t'(1)) begin
                            result1_q <= wait_res;
                            err1_q    <= wait_err;
                            done1_q   <= 1'b1;
                        end else begin
                            result0_q <= wait_res;
                            err0_q    <= wait_err;
                            done0_q   <= 1'b1;
                        end
                        u_ce_q  <= 1'b0;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                ST_RESP: begin
                    last_q  <= owner_q;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    u_ce_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign u_start = u_start_q;
    assign u_ce    = u_ce_q;
    assign u_op    = u_req_q.op;
    assign u_A     = u_req_q.a;
    assign u_B     = u_req_q.b;
    assign busy    = busy_q;
    assign done0   = done0_q;
    assign done1   = done1_q;
    assign err0    = err0_q;
    assign err1    = err1_q;
    assign result0 = result0_q;
    assign result1 = result1_q;

endmodule

// File: tb/tb_c_addsub_shared_ctrl.sv
// ----------------------------------------------------------------------------
// tb_c_addsub_shared_ctrl
// Bench for the shared add/sub controller. A behavioural stub plays the
// shared unit; expected completions are queued when a request is driven and
// matched against every done pulse by a monitor.
// ----------------------------------------------------------------------------
module tb_c_addsub_shared_ctrl;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        req0, req1;
    logic [63:0] A0, B0, A1, B1;
    logic        op0, op1;
    logic        done0, done1, err0, err1;
    logic [63:0] result0, result1;
    logic        u_start, u_ce, u_op;
    logic [63:0] u_A, u_B;
    logic [63:0] u_result;
    logic        u_finish;
    logic        busy;

    c_addsub_shared_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .A0       (A0),
        .B0       (B0),
        .A1       (A1),
        .B1       (B1),
        .op0      (op0),
        .op1      (op1),
        .done0    (done0),
        .done1    (done1),
        .err0     (err0),
        .err1     (err1),
        .result0  (result0),
        .result1  (result1),
        .u_start  (u_start),
        .u_ce     (u_ce),
        .u_op     (u_op),
        .u_A      (u_A),
        .u_B      (u_B),
        .u_result (u_result),
        .u_finish (u_finish),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic used by the stub unit and for expected results.
    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b, input logic op);
        logic [31:0] re, im;
        re = op ? (a[63:32] - b[63:32]) : (a[63:32] + b[63:32]);
        im = op ? (a[31:0]  - b[31:0])  : (a[31:0]  + b[31:0]);
        return {re, im};
    endfunction

    // ------------------------------------------------------------------------
    // Stub unit: raises u_finish in WAIT cycle stub_lat (never if negative).
    // With stub_hold set, finish stays high until the next op's first WAIT
    // cycle, mimicking a unit that keeps finish asserted between operations.
    // ------------------------------------------------------------------------
    int          stub_lat   = 0;
    bit          stub_force = 1'b0;
    logic [63:0] stub_val   = '0;
    bit          stub_hold  = 1'b0;

    initial begin : stub
        int t;
        t        = -1;
        u_finish = 1'b0;
        u_result = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                u_finish = 1'b0;
                t        = -1;
            end else begin
                if (u_start) t = 0;
                else if (t >= 0) t++;
                if (stub_lat >= 0 && t == 2 + stub_lat) begin
                    u_finish = 1'b1;
                    u_result = stub_force ? stub_val : model(u_A, u_B, u_op);
                end else if (!stub_hold || t == 2) begin
                    u_finish = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    typedef struct {
        bit          id;
        logic [63:0] res;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    task automatic push_exp(input bit id, input logic [63:0] res, input bit err, input int c);
        exp_t e;
        e.id  = id;
        e.res = res;
        e.err = err;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (done0 || done1)) begin
                check("done_exclusive", 64'(done0 & done1), 64'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'({done1, done0}), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_owner",  64'(done1), 64'(e.id));
                    check("done_cycle",  64'(cyc), 64'(e.cyc));
                    check("done_result", done1 ? result1 : result0, e.res);
                    check("done_err",    64'(done1 ? err1 : err0), 64'(e.err));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Advance to the posedge where cyc reaches n, then step off the edge.
    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ------------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------------
    typedef struct {
        bit          req0, req1;
        logic [63:0] a0, b0, a1, b1;
        bit          op0, op1;
        int          lat;
        bit          force_en;
        logic [63:0] force_val;
        bit          exp_id;
        bit          exp_err;
        logic [63:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mk(input bit r0, input bit r1,
                                input logic [63:0] a0, input logic [63:0] b0, input bit o0,
                                input logic [63:0] a1, input logic [63:0] b1, input bit o1,
                                input int lat, input bit exp_id);
        vec_t v;
        v.req0 = r0;  v.req1 = r1;
        v.a0 = a0;    v.b0 = b0;   v.op0 = o0;
        v.a1 = a1;    v.b1 = b1;   v.op1 = o1;
        v.lat       = lat;
        v.force_en  = 1'b0;
        v.force_val = '0;
        v.exp_id    = exp_id;
        v.exp_err   = (lat < 0);
        v.exp_res   = (lat < 0) ? 64'd0 : (exp_id ? model(a1, b1, o1) : model(a0, b0, o0));
        v.exp_lat   = (lat < 0) ? 4 + TO : 4 + lat;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int          c0;
        logic [63:0] ga, gb;
        bit          gop;
        stub_lat   = v.lat;
        stub_force = v.force_en;
        stub_val   = v.force_val;
        A0 = v.a0; B0 = v.b0; op0 = v.op0;
        A1 = v.a1; B1 = v.b1; op1 = v.op1;
        req0 = v.req0;
        req1 = v.req1;
        c0 = cyc;
        push_exp(v.exp_id, v.exp_res, v.exp_err, c0 + v.exp_lat);
        ga  = v.exp_id ? v.a1  : v.a0;
        gb  = v.exp_id ? v.b1  : v.b0;
        gop = v.exp_id ? v.op1 : v.op0;
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        check($sformatf("v%0d_u_start", idx), 64'(u_start), 64'd1);
        check($sformatf("v%0d_u_ce", idx),    64'(u_ce),    64'd1);
        check($sformatf("v%0d_busy", idx),    64'(busy),    64'd1);
        check($sformatf("v%0d_u_A", idx),     u_A, ga);
        check($sformatf("v%0d_u_B", idx),     u_B, gb);
        check($sformatf("v%0d_u_op", idx),    64'(u_op), 64'(gop));
        @(posedge clk);
        #1;
        check($sformatf("v%0d_start_once", idx), 64'(u_start), 64'd0);
        wait_cyc(c0 + v.exp_lat + 2);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 64'({busy, u_ce, u_start, u_op, done0, done1, err0, err1}), 64'd0);
        check({tag, "_u_A"}, u_A, 64'd0);
        check({tag, "_u_B"}, u_B, 64'd0);
        check({tag, "_result0"}, result0, 64'd0);
        check({tag, "_result1"}, result1, 64'd0);
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin : main
        int c0, c1;
        logic [63:0] ta0, tb0, ta1, tb1;

        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        A0 = '0; B0 = '0; A1 = '0; B1 = '0;
        op0 = 1'b0; op1 = 1'b0;

        // Winners follow 'last' starting at 1: 0,1,0(tie),0,1,0,1(tie).
        vecs[0] = mk(1, 0, 64'h3F800000_40000000, 64'h40000000_3F800000, 0,
                     64'h0, 64'h0, 0, 0, 0);
        vecs[0].force_en  = 1'b1;
        vecs[0].force_val = 64'h40400000_40400000;
        vecs[0].exp_res   = 64'h40400000_40400000;
        vecs[1] = mk(0, 1, 64'h0, 64'h0, 0,
                     64'h00000010_00000020, 64'h00000001_00000030, 1, 2, 1);
        vecs[2] = mk(1, 1, 64'h11111111_22222222, 64'h01010101_02020202, 0,
                     64'hAAAA0000_BBBB0000, 64'h00001111_00002222, 1, 1, 0);
        vecs[3] = mk(1, 0, 64'hFFFFFFFF_00000001, 64'h00000001_FFFFFFFF, 0,
                     64'h0, 64'h0, 0, TO, 0);
        vecs[4] = mk(0, 1, 64'h0, 64'h0, 0,
                     64'h12345678_9ABCDEF0, 64'h0FEDCBA9_87654321, 0, -1, 1);
        vecs[5] = mk(1, 0, 64'h00000005_00000007, 64'h00000003_00000009, 1,
                     64'h0, 64'h0, 0, 1, 0);
        vecs[6] = mk(1, 1, 64'h80000000_7FFFFFFF, 64'h80000000_00000001, 0,
                     64'hDEADBEEF_CAFEF00D, 64'h00000001_00000001, 1, 5, 1);

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        // Tie held continuously: grants alternate 0,1,0,1, dones 5 apart.
        stub_lat = 0; stub_force = 1'b0;
        ta0 = 64'h00000100_00000200; tb0 = 64'h00000001_00000002;
        ta1 = 64'h00000300_00000400; tb1 = 64'h00000003_00000004;
        A0 = ta0; B0 = tb0; op0 = 1'b0;
        A1 = ta1; B1 = tb1; op1 = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        c0 = cyc;
        push_exp(0, model(ta0, tb0, 0), 0, c0 + 4);
        push_exp(1, model(ta1, tb1, 1), 0, c0 + 9);
        push_exp(0, model(ta0, tb0, 0), 0, c0 + 14);
        push_exp(1, model(ta1, tb1, 1), 0, c0 + 19);
        wait_cyc(c0 + 19);
        req0 = 1'b0; req1 = 1'b0;
        wait_cyc(c0 + 21);

        // Operand isolation: A0 changes the cycle after grant.
        stub_lat = 2;
        ta0 = 64'h00000050_00000060; tb0 = 64'h00000005_00000006;
        A0 = ta0; B0 = tb0; op0 = 1'b0;
        req0 = 1'b1;
        c0 = cyc;
        push_exp(0, model(ta0, tb0, 0), 0, c0 + 6);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        A0 = 64'hFFFF0000_FFFF0000;
        @(posedge clk);
        #1;
        check("iso_u_A_arm", u_A, ta0);
        @(posedge clk);
        #1;
        check("iso_u_A_wait", u_A, ta0);
        wait_cyc(c0 + 8);

        // Stale finish: finish held high through ISSUE/ARM of the next op.
        stub_hold = 1'b1;
        stub_lat  = 0;
        A1 = 64'h00000007_00000008; B1 = 64'h00000002_00000003; op1 = 1'b1;
        req1 = 1'b1;
        c0 = cyc;
        push_exp(1, model(A1, B1, 1), 0, c0 + 4);
        @(posedge clk);
        #1;
        req1 = 1'b0;
        wait_cyc(c0 + 6);
        stub_lat = 3;
        A0 = 64'h00000009_0000000A; B0 = 64'h00000001_00000001; op0 = 1'b0;
        req0 = 1'b1;
        c1 = cyc;
        push_exp(0, model(A0, B0, 0), 0, c1 + 7);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        wait_cyc(c1 + 9);
        stub_hold = 1'b0;
        wait_cyc(c1 + 11);

        // Reset during WAIT: no done, all outputs zero, next tie goes to 0.
        stub_lat = -1;
        A0 = 64'h00000001_00000001; B0 = 64'h00000001_00000001;
        req0 = 1'b1;
        c0 = cyc;
        @(posedge clk);
        #1;
        req0 = 1'b0;
        wait_cyc(c0 + 5);
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("post_rst_no_start", 64'({u_start, busy}), 64'd0);
        stub_lat = 0;
        A0 = 64'h00000021_00000022; B0 = 64'h00000001_00000002; op0 = 1'b1;
        A1 = 64'h00000031_00000032; B1 = 64'h00000001_00000002; op1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        c0 = cyc;
        push_exp(0, model(A0, B0, 1), 0, c0 + 4);
        @(posedge clk);
        #1;
        req0 = 1'b0; req1 = 1'b0;
        wait_cyc(c0 + 8);

        check("pending_expectations", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/c_addsub_shared_ctrl.md
# c_addsub_shared_ctrl

Two-requester scheduler that shares one `complex_adder_subtractor_with_start` unit between two clients. Each requester presents a 64-bit complex operand pair plus an op bit. The controller:
- arbitrates round-robin,
- registers the granted operands,
- pulses the unit's `start`, waits for `finish` (bounded by a timeout),
- returns the 64-bit result with a one-cycle `done` to the winner.

It sits between the complex-arithmetic clients and the single shared add/sub datapath.

## Interface
Parameters:
- `TIMEOUT_CYC`, 64, maximum WAIT cycles before aborting; legal range 2..255.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req0`, `req1`  in  1  request level per requester
- `A0`, `B0`, `A1`, `B1`  in  64  operands, {real[63:32], imj[31:0]}
- `op0`, `op1`  in  1  op bit, passed unchanged to unit
- `done0`, `done1`  out  1  one-cycle completion pulse
- `err0`, `err1`  out  1  valid with done: 1 = timeout abort
- `result0`, `result1`  out  64  result, held until next done to same requester
- `u_start`  out  1  start pulse to shared unit
- `u_ce`  out  1  clock enable to shared unit
- `u_op`  out  1  op to shared unit
- `u_A`, `u_B`  out  64  operands to shared unit
- `u_result`  in  64  unit result
- `u_finish`  in  1  unit completion
- `busy`  out  1  high in any state except IDLE

## Operation
States:
- **IDLE**
  - Sample `req0`/`req1`.
  - If any are high: pick winner, latch its A/B/op into `u_A`/`u_B`/`u_op`, record owner, go to ISSUE.
- **ISSUE**
  - `u_start`=1 for exactly this cycle.
  - Go to ARM.
- **ARM**
  - One guard cycle; `u_finish` is ignored here and in ISSUE, since it may still be high from the previous op.
  - Clear the timeout counter; go to WAIT.
- **WAIT**
  - If `u_finish`=1: capture `u_result` into owner's result register, err=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT_CYC`: owner's result ← 0, err=1, go to RESP.
- **RESP**
  - Owner's done=1 for this cycle only.
  - Update `last` ← owner; go to IDLE.

Arbitration:
- Only one request is high: that requester wins.
- Both are high: the requester ≠ `last` wins.
- `last` resets to 1, so requester 0 wins the first tie.

Other rules:
- `u_ce`=1 in ISSUE, ARM and WAIT; 0 in IDLE and RESP.
- `req` is a level. A requester still holding `req` in the IDLE cycle after its done is treated as a new request. With both high, the other requester wins that tie.
- `req` dropped mid-operation: the op completes and done still pulses. Operands are registered at grant, so input changes after grant have no effect.
- There is no arithmetic in the controller; `result` is `u_result` bit-for-bit.

## Timing
- Reset (async assert): state=IDLE, `last`=1, counter=0. All outputs 0: done*, err*, result*, u_*, `busy`.
- Reset asserted mid-operation: the operation is dropped silently, with no done pulse. The unit's `start` is not re-issued after reset release.
- Latency: `req` high in IDLE cycle 0 → ISSUE in cycle 1 → ARM in cycle 2 → WAIT from cycle 3. If `u_finish` is seen in WAIT cycle 3+k, done is asserted in cycle 4+k.
- Minimum request-to-done is 4 cycles. Back-to-back ops cost 5+k cycles each, because the IDLE cycle is included.
- Timeout: done with err=1 in cycle 4+`TIMEOUT_CYC`.
- A `u_finish` arriving in the same WAIT cycle that the counter hits the limit counts as success (err=0).
- `u_finish` is ignored in IDLE, ISSUE, ARM and RESP.

## Structure
Shared package `c_addsub_pkg` holds:
- the state encoding (IDLE, ISSUE, ARM, WAIT, RESP),
- `CPLX_W`=64 and `PART_W`=32,
- the requester-ID width.

One natural sub-module is `rr_arbiter2`. It takes the two request levels and `last`, and returns grant and owner; it is purely combinational. The FSM, timeout counter and output registers live in the top.

## Test plan
- **Single add:** `req0`=1, `A0`=0x3F800000_40000000, `B0`=0x40000000_3F800000, `op0`=0. Stub asserts `u_finish` on the first WAIT cycle with result 0x40400000_40400000. Required: `u_start` pulses in cycle 1, `done0` in cycle 4, `result0`=0x40400000_40400000, `err0`=0, `done1` never asserts.
- **Tie / round-robin:** `req0`=`req1`=1 held continuously. Grants alternate 0,1,0,1. Each done is 5 cycles apart with stub latency 0. No requester waits for more than one other op.
- **Operand isolation:** change `A0` the cycle after grant. `u_A` keeps the granted value and the result reflects the original operands.
- **Stale finish:** stub holds `u_finish`=1 from the previous op through ISSUE and ARM, then drops and raises it 3 cycles into WAIT. Done appears in cycle 7, not cycle 2.
- **Timeout:** `TIMEOUT_CYC`=8 and the stub never finishes. Required: `done1` with `err1`=1 and `result1`=0 in cycle 12. The next request is then served normally.
- **Reset mid-WAIT:** assert `rst` during WAIT. All outputs go to 0 immediately and there is no done. After release, a `req0`/`req1` tie grants requester 0.
